// File: rtl/mux32_32x1.sv
// rtl/mux32_32x1.sv - registered 32:1 word selector with 4:1, 8:1 and 16:1 taps
module mux32_32x1 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic [WIDTH-1:0] I5,
  input  logic [WIDTH-1:0] I6,
  input  logic [WIDTH-1:0] I7,
  input  logic [WIDTH-1:0] I8,
  input  logic [WIDTH-1:0] I9,
  input  logic [WIDTH-1:0] I10,
  input  logic [WIDTH-1:0] I11,
  input  logic [WIDTH-1:0] I12,
  input  logic [WIDTH-1:0] I13,
  input  logic [WIDTH-1:0] I14,
  input  logic [WIDTH-1:0] I15,
  input  logic [WIDTH-1:0] I16,
  input  logic [WIDTH-1:0] I17,
  input  logic [WIDTH-1:0] I18,
  input  logic [WIDTH-1:0] I19,
  input  logic [WIDTH-1:0] I20,
  input  logic [WIDTH-1:0] I21,
  input  logic [WIDTH-1:0] I22,
  input  logic [WIDTH-1:0] I23,
  input  logic [WIDTH-1:0] I24,
  input  logic [WIDTH-1:0] I25,
  input  logic [WIDTH-1:0] I26,
  input  logic [WIDTH-1:0] I27,
  input  logic [WIDTH-1:0] I28,
  input  logic [WIDTH-1:0] I29,
  input  logic [WIDTH-1:0] I30,
  input  logic [WIDTH-1:0] I31,
  input  logic [4:0]       S,
  output logic [WIDTH-1:0] Y_4x1,
  output logic [WIDTH-1:0] Y_8x1,
  output logic [WIDTH-1:0] Y_16x1,
  output logic [WIDTH-1:0] Y_32x1
);

  logic [WIDTH-1:0] in_w [32];
  logic [WIDTH-1:0] l1 [8];
  logic [WIDTH-1:0] l2 [4];
  logic [WIDTH-1:0] l3 [2];
  logic [WIDTH-1:0] l4;

  assign in_w[0]  = I0;
  assign in_w[1]  = I1;
  assign in_w[2]  = I2;
  assign in_w[3]  = I3;
  assign in_w[4]  = I4;
  assign in_w[5]  = I5;
  assign in_w[6]  = I6;
  assign in_w[7]  = I7;
  assign in_w[8]  = I8;
  assign in_w[9]  = I9;
  assign in_w[10] = I10;
  assign in_w[11] = I11;
  assign in_w[12] = I12;
  assign in_w[13] = I13;
  assign in_w[14] = I14;
  assign in_w[15] = I15;
  assign in_w[16] = I16;
  assign in_w[17] = I17;
  assign in_w[18] = I18;
  assign in_w[19] = I19;
  assign in_w[20] = I20;
  assign in_w[21] = I21;
  assign in_w[22] = I22;
  assign in_w[23] = I23;
  assign in_w[24] = I24;
  assign in_w[25] = I25;
  assign in_w[26] = I26;
  assign in_w[27] = I27;
  assign in_w[28] = I28;
  assign in_w[29] = I29;
  assign in_w[30] = I30;
  assign in_w[31] = I31;

  // Level 1: group g covers I[4g .. 4g+3], picked by S[1:0]
  for (genvar g = 0; g < 8; g++) begin : g_l1
    assign l1[g] = in_w[{3'(g), S[1:0]}];
  end

  for (genvar g = 0; g < 4; g++) begin : g_l2
    assign l2[g] = S[2] ? l1[2*g+1] : l1[2*g];
  end

  for (genvar g = 0; g < 2; g++) begin : g_l3
    assign l3[g] = S[3] ? l2[2*g+1] : l2[2*g];
  end

  assign l4 = S[4] ? l3[1] : l3[0];

  // Taps are the index-0 branch of each level, so they ignore higher select bits
  always_ff @(posedge CLK) begin
    if (RST) begin
      Y_4x1  <= '0;
      Y_8x1  <= '0;
      Y_16x1 <= '0;
      Y_32x1 <= '0;
    end else begin
      Y_4x1  <= l1[0];
      Y_8x1  <= l2[0];
      Y_16x1 <= l3[0];
      Y_32x1 <= l4;
    end
  end

endmodule

// File: tb/tb_mux32_32x1.sv
// tb/tb_mux32_32x1.sv - directed self-checking bench for mux32_32x1
module tb_mux32_32x1;

  logic        clk;
  logic        rst;
  logic [4:0]  s;
  logic [31:0] d [32];
  logic [31:0] y4, y8, y16, y32;
  int          vectors = 0;
  int          miscompares = 0;

  mux32_32x1 #(.WIDTH(32)) dut (
    .CLK(clk), .RST(rst),
    .I0(d[0]),   .I1(d[1]),   .I2(d[2]),   .I3(d[3]),
    .I4(d[4]),   .I5(d[5]),   .I6(d[6]),   .I7(d[7]),
    .I8(d[8]),   .I9(d[9]),   .I10(d[10]), .I11(d[11]),
    .I12(d[12]), .I13(d[13]), .I14(d[14]), .I15(d[15]),
    .I16(d[16]), .I17(d[17]), .I18(d[18]), .I19(d[19]),
    .I20(d[20]), .I21(d[21]), .I22(d[22]), .I23(d[23]),
    .I24(d[24]), .I25(d[25]), .I26(d[26]), .I27(d[27]),
    .I28(d[28]), .I29(d[29]), .I30(d[30]), .I31(d[31]),
    .S(s),
    .Y_4x1(y4), .Y_8x1(y8), .Y_16x1(y16), .Y_32x1(y32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [31:0] e4, input logic [31:0] e8,
                      input logic [31:0] e16, input logic [31:0] e32);
    chk({tag, " Y_4x1"},  y4,  e4);
    chk({tag, " Y_8x1"},  y8,  e8);
    chk({tag, " Y_16x1"}, y16, e16);
    chk({tag, " Y_32x1"}, y32, e32);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] h;
    logic [4:0]  prev;

    for (int n = 0; n < 15; n++) d[n] = 32'(n + 1) * 32'h1111_1111;
    d[15] = 32'h1000_1000;
    for (int k = 0; k < 16; k++) begin
      h = 16'h1001 + 16'(k);
      d[16+k] = {h, h};
    end

    rst = 1'b1;
    s   = 5'h1f;
    tick();
    chk4("reset edge 1", 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk4("reset edge 2", 32'h0, 32'h0, 32'h0, 32'h0);

    rst = 1'b0;
    s   = 5'h00;
    tick();
    chk4("release S=00", 32'h1111_1111, 32'h1111_1111, 32'h1111_1111, 32'h1111_1111);

    s = 5'h05;
    tick();
    chk4("S=05", 32'h2222_2222, 32'h6666_6666, 32'h6666_6666, 32'h6666_6666);

    s = 5'h13;
    tick();
    chk4("S=13", 32'h4444_4444, 32'h4444_4444, 32'h4444_4444, 32'h1004_1004);

    s = 5'h1f;
    tick();
    chk4("S=1f", 32'h4444_4444, 32'h8888_8888, 32'h1000_1000, 32'h1010_1010);

    // Sweep: S moves on right after each edge, outputs must still show the sampled S
    for (int i = 0; i < 32; i++) begin
      s = 5'(i);
      tick();
      prev = s;
      s = 5'(i + 1);
      #1;
      chk4($sformatf("sweep S=%02h", prev),
           d[{3'b0, prev[1:0]}], d[{2'b0, prev[2:0]}], d[{1'b0, prev[3:0]}], d[prev]);
    end
    s = 5'h00;
    tick();
    chk4("sweep end S=00", 32'h1111_1111, 32'h1111_1111, 32'h1111_1111, 32'h1111_1111);

    s = 5'h0a;
    tick();
    chk4("S=0a before change", 32'h3333_3333, 32'h3333_3333, 32'hbbbb_bbbb, 32'hbbbb_bbbb);
    d[10] = 32'h0123_4567;
    #2;
    chk4("I10 changed, no edge", 32'h3333_3333, 32'h3333_3333, 32'hbbbb_bbbb, 32'hbbbb_bbbb);
    tick();
    chk4("I10 changed, after edge", 32'h3333_3333, 32'h3333_3333, 32'h0123_4567, 32'h0123_4567);

    s   = 5'h1f;
    rst = 1'b1;
    tick();
    chk4("mid-stream reset", 32'h0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    chk4("post reset S=1f", 32'h4444_4444, 32'h8888_8888, 32'h1000_1000, 32'h1010_1010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux32_32x1.md
# mux32_32x1

Registered 32-input word selector for the processor datapath. It selects one of 32 words with a 5-bit select and also exposes the 4:1, 8:1 and 16:1 sub-tree results, which use the low select bits over I0..I3, I0..I7 and I0..I15. Register-file read ports and ALU result muxes use these taps. All four results are registered on one clock with a synchronous active-high reset.

## Interface
- WIDTH, default 32: width of every data input and output; all requirements below assume 32.
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  reset; synchronous and active-high, sampled on rising CLK.
- I0 .. I31  input  WIDTH each  data words; index n is selected when the relevant select field equals n.
- S  input  5  select code.
- Y_4x1  output  WIDTH  registered I[S[1:0]], choosing among I0..I3.
- Y_8x1  output  WIDTH  registered I[S[2:0]], choosing among I0..I7.
- Y_16x1  output  WIDTH  registered I[S[3:0]], choosing among I0..I15.
- Y_32x1  output  WIDTH  registered I[S[4:0]], choosing among I0..I31.

## Operation
- Combinational tree:
  - Level 1: eight 4:1 muxes on S[1:0] over groups {I0-I3}, {I4-I7}, … , {I28-I31}.
  - Level 2: 2:1 muxes on S[2], giving four 8:1 results.
  - Level 3: 2:1 muxes on S[3], giving two 16:1 results.
  - Level 4: a 2:1 mux on S[4], giving the 32:1 result.
- Taps:
  - The 4:1 tap is level-1 group 0.
  - The 8:1 tap is level-2 result 0.
  - The 16:1 tap is level-3 result 0.
  - The 32:1 tap is the final result.
  - Each tap therefore ignores the select bits above its width. Example: S=5'h13 gives Y_4x1 = I3.
- Selection is pure bitwise pass-through: no arithmetic, no sign handling, no bit reordering.
- Every S value 0..31 is legal; there is no undefined or X-producing select code.
- Each output is a WIDTH-bit register loaded from its tap.
- No state machine; the output registers are the only state.

## Timing
- Reset:
  - When RST=1 at a rising CLK edge, all four outputs become 32'h0000_0000 after that edge.
  - Reset overrides any data or select activity in the same cycle.
  - Outputs hold 0 every cycle RST stays high.
- Latency is exactly 1 cycle. S and I0..I31 sampled at edge k appear on the outputs after edge k and hold until edge k+1.
- A change of S or of any I input between edges has no effect on the outputs until the next edge.
- Simultaneous S change and data change in the same cycle: the output reflects the new S applied to the new data.
- Reset released mid-stream: the first edge with RST=0 loads the taps normally. No warm-up cycles, no stale data.
- Before the first reset edge the outputs are unspecified. The bench must reset before checking.
- The combinational path from S or I to the register D inputs must meet one clock period.
- No enable, handshake or valid signals: the block loads every cycle.

## Test plan
Unless stated otherwise, load I0..I14 = 32'h1111_1111, 32'h2222_2222, … , 32'hffff_ffff (nibble-repeated n+1). Load I15 = 32'h1000_1000 and I16..I31 = 32'h1001_1001 .. 32'h1010_1010.

- Reset: RST=1 for 2 edges with S=5'h1f and data loaded -> all four outputs 32'h0 after each reset edge. Release RST with S=0 -> after the next edge all outputs = 32'h1111_1111.
- Low-index sweep, S=5'h05 -> after one edge: Y_4x1=32'h2222_2222; Y_8x1, Y_16x1 and Y_32x1 = 32'h6666_6666.
- Upper-bit masking, S=5'h13 -> Y_4x1, Y_8x1 and Y_16x1 = 32'h4444_4444; Y_32x1=32'h1004_1004.
- Max index, S=5'h1f -> Y_4x1=32'h4444_4444, Y_8x1=32'h8888_8888, Y_16x1=32'h1000_1000, Y_32x1=32'h1010_1010.
- Full sweep and latency:
  - Stimulus: step S 0..31 then back to 0, one value per cycle.
  - Required: each output equals the expected tap for the S sampled one edge earlier, never the current S. After the final S=0, all outputs = 32'h1111_1111.
- Data change without select change: hold S=5'h0a and change I10 from 32'hbbbb_bbbb to 32'h0123_4567 between edges. Required: Y_16x1 and Y_32x1 = 32'hbbbb_bbbb until the next edge, then 32'h0123_4567. Y_4x1 = I2 = 32'h3333_3333 throughout.
